aq_djpeg_mcu_sched: RTL and testbench

AQ_DJPEG_MCU_SCHED -- requirements
Module: aq_djpeg_mcu_sched

---
 rtl/aq_djpeg_mcu_sched.sv | 201 ++++++++++++++++++++
 tb/tb_aq_djpeg_mcu_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_djpeg_mcu_sched.sv
// aq_djpeg_mcu_sched
// ------------------
// MCU / block scheduler for the baseline JPEG decoder. It walks the decoder
// through every 8x8 block of every MCU in a scan, tracks the MCU position,
// and inserts restart-marker handling every JpegRestart MCUs.
//
// Handshake: BlockDone and MarkerDone are single-cycle pulses from the
// Huffman/IDCT path and the bitstream feeder. A pulse is acted on only in
// the state that is waiting for it (BlockDone in RUN, MarkerDone in
// WAIT_MARK) and is otherwise dropped. There is no back-pressure.
//
// Ports
//   rst            async active-low reset
//   clk            clock
//   ProcessInit    synchronous clear to IDLE; wins over every other event
//   Start          pulse, IDLE -> RUN
//   JpegComp       component count (3 = YCbCr, else grayscale)
//   SubSamplingW/H luma blocks per MCU minus 1 (values above 1 act as 1)
//   JpegMcuWidth   MCUs per row
//   JpegMcuHeight  MCU rows
//   JpegRestart    restart interval in MCUs, 0 = none
//   BlockDone      pulse, current block decoded
//   MarkerDone     pulse, RSTn marker consumed
//   DecodeEnable   high only while in RUN
//   BlockColor     0 = Y, 1 = Cb, 2 = Cr
//   BlockIndex     luma sub-block index (0 for chroma)
//   McuX, McuY     current MCU position
//   McuDone        one-cycle pulse per completed MCU
//   ResetDC        DC predictor reset, high during ALIGN
//   AlignReq       byte-align request, high during ALIGN
//   Finish         level, high in DONE until ProcessInit
//   DebugState     current FSM state encoding
module aq_djpeg_mcu_sched (
  input  logic        rst,
  input  logic        clk,
  input  logic        ProcessInit,
  input  logic        Start,
  input  logic [2:0]  JpegComp,
  input  logic [1:0]  SubSamplingW,
  input  logic [1:0]  SubSamplingH,
  input  logic [11:0] JpegMcuWidth,
  input  logic [11:0] JpegMcuHeight,
  input  logic [15:0] JpegRestart,
  input  logic        BlockDone,
  input  logic        MarkerDone,
  output logic        DecodeEnable,
  output logic [2:0]  BlockColor,
  output logic [1:0]  BlockIndex,
  output logic [11:0] McuX,
  output logic [11:0] McuY,
  output logic        McuDone,
  output logic        ResetDC,
  output logic        AlignReq,
  output logic        Finish,
  output logic [2:0]  DebugState
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    ALIGN     = 3'd2,
    WAIT_MARK = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [2:0]  colorNext;
  logic [1:0]  indexNext;
  logic [11:0] mcuXNext;
  logic [11:0] mcuYNext;
  logic [15:0] rstCnt;
  logic [15:0] rstCntNext;
  logic        mcuDoneNext;

  logic        isColor;
  logic        wide;
  logic        tall;
  logic [1:0]  lastLuma;
  logic        lumaLast;
  logic        lastBlock;
  logic        lastCol;
  logic        lastRow;
  logic        restartHit;

  assign isColor = (JpegComp == 3'd3);
  // Sub-sampling only matters for colour scans; 2 and 3 collapse to 1.
  assign wide    = isColor & (|SubSamplingW);
  assign tall    = isColor & (|SubSamplingH);
  // Index of the last luma block: 1 block -> 0, 2 blocks -> 1, 4 blocks -> 3.
  assign lastLuma  = {wide & tall, wide | tall};
  assign lumaLast  = (BlockColor == 3'd0) && (BlockIndex == lastLuma);
  assign lastBlock = isColor ? (BlockColor == 3'd2) : lumaLast;
  assign lastCol   = (McuX == JpegMcuWidth - 12'd1);
  assign lastRow   = (McuY == JpegMcuHeight - 12'd1);
  assign restartHit = (JpegRestart != 16'd0) && (rstCnt + 16'd1 == JpegRestart);

  assign DebugState = state;

  always_comb begin
    stateNext   = state;
    colorNext   = BlockColor;
    indexNext   = BlockIndex;
    mcuXNext    = McuX;
    mcuYNext    = McuY;
    rstCntNext  = rstCnt;
    mcuDoneNext = 1'b0;
    if (ProcessInit) begin
      stateNext  = IDLE;
      colorNext  = 3'd0;
      indexNext  = 2'd0;
      mcuXNext   = 12'd0;
      mcuYNext   = 12'd0;
      rstCntNext = 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) stateNext = RUN;
        end
        RUN: begin
          if (BlockDone) begin
            if (!lastBlock) begin
              if (!lumaLast && BlockColor == 3'd0) begin
                indexNext = BlockIndex + 2'd1;
              end else begin
                // Y -> Cb or Cb -> Cr; chroma always uses index 0.
                colorNext = BlockColor + 3'd1;
                indexNext = 2'd0;
              end
            end else begin
              colorNext   = 3'd0;
              indexNext   = 2'd0;
              mcuDoneNext = 1'b1;
              if (lastCol && lastRow) begin
                // Final MCU: position is held, and a coincident restart
                // boundary is irrelevant because the scan is over.
                stateNext = DONE;
              end else begin
                if (lastCol) begin
                  mcuXNext = 12'd0;
                  mcuYNext = McuY + 12'd1;
                end else begin
                  mcuXNext = McuX + 12'd1;
                end
                if (restartHit) begin
                  rstCntNext = 16'd0;
                  stateNext  = ALIGN;
                end else begin
                  rstCntNext = rstCnt + 16'd1;
                end
              end
            end
          end
        end
        ALIGN: begin
          stateNext = WAIT_MARK;
        end
        WAIT_MARK: begin
          if (MarkerDone) stateNext = RUN;
        end
        DONE: begin
          stateNext = DONE;
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      BlockColor   <= 3'd0;
      BlockIndex   <= 2'd0;
      McuX         <= 12'd0;
      McuY         <= 12'd0;
      rstCnt       <= 16'd0;
      McuDone      <= 1'b0;
      DecodeEnable <= 1'b0;
      AlignReq     <= 1'b0;
      ResetDC      <= 1'b0;
      Finish       <= 1'b0;
    end else begin
      state        <= stateNext;
      BlockColor   <= colorNext;
      BlockIndex   <= indexNext;
      McuX         <= mcuXNext;
      McuY         <= mcuYNext;
      rstCnt       <= rstCntNext;
      McuDone      <= mcuDoneNext;
      DecodeEnable <= (stateNext == RUN);
      AlignReq     <= (stateNext == ALIGN);
      ResetDC      <= (stateNext == ALIGN);
      Finish       <= (stateNext == DONE);
    end
  end

endmodule

// File: tb/tb_aq_djpeg_mcu_sched.sv
// Testbench for aq_djpeg_mcu_sched: directed scans with a behavioural
// scan-position model compared against the DUT on every falling edge,
// plus literal checks of the hand-computed scenarios.
module tb_aq_djpeg_mcu_sched;

  logic        rst;
  logic        clk;
  logic        ProcessInit;
  logic        Start;
  logic [2:0]  JpegComp;
  logic [1:0]  SubSamplingW;
  logic [1:0]  SubSamplingH;
  logic [11:0] JpegMcuWidth;
  logic [11:0] JpegMcuHeight;
  logic [15:0] JpegRestart;
  logic        BlockDone;
  logic        MarkerDone;
  logic        DecodeEnable;
  logic [2:0]  BlockColor;
  logic [1:0]  BlockIndex;
  logic [11:0] McuX;
  logic [11:0] McuY;
  logic        McuDone;
  logic        ResetDC;
  logic        AlignReq;
  logic        Finish;
  logic [2:0]  DebugState;

  int checks = 0;
  int errors = 0;

  aq_djpeg_mcu_sched dut (
    .rst(rst), .clk(clk), .ProcessInit(ProcessInit), .Start(Start),
    .JpegComp(JpegComp), .SubSamplingW(SubSamplingW), .SubSamplingH(SubSamplingH),
    .JpegMcuWidth(JpegMcuWidth), .JpegMcuHeight(JpegMcuHeight),
    .JpegRestart(JpegRestart), .BlockDone(BlockDone), .MarkerDone(MarkerDone),
    .DecodeEnable(DecodeEnable), .BlockColor(BlockColor), .BlockIndex(BlockIndex),
    .McuX(McuX), .McuY(McuY), .McuDone(McuDone), .ResetDC(ResetDC),
    .AlignReq(AlignReq), .Finish(Finish), .DebugState(DebugState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // The scan is described by linear block and MCU numbers; position and
  // colour are derived from them with plain arithmetic.
  localparam int P_IDLE = 0, P_RUN = 1, P_ALIGN = 2, P_WAIT = 3, P_DONE = 4;
  int mPhase = P_IDLE;
  int mBlk   = 0;
  int mMcu   = 0;
  bit mPulse = 1'b0;

  function automatic int luma_count();
    int sw, sh;
    if (JpegComp != 3'd3) return 1;
    sw = (SubSamplingW > 2'd1) ? 1 : int'(SubSamplingW);
    sh = (SubSamplingH > 2'd1) ? 1 : int'(SubSamplingH);
    return (sw + 1) * (sh + 1);
  endfunction

  function automatic int blocks_per_mcu();
    return luma_count() + ((JpegComp == 3'd3) ? 2 : 0);
  endfunction

  function automatic int width_safe();
    return (JpegMcuWidth == 12'd0) ? 1 : int'(JpegMcuWidth);
  endfunction

  always @(posedge clk or negedge rst) begin
    int ph, blk, mcu;
    bit pl;
    if (!rst) begin
      mPhase <= P_IDLE;
      mBlk   <= 0;
      mMcu   <= 0;
      mPulse <= 1'b0;
    end else begin
      ph = mPhase; blk = mBlk; mcu = mMcu; pl = 1'b0;
      if (ProcessInit) begin
        ph = P_IDLE; blk = 0; mcu = 0;
      end else if (ph == P_IDLE) begin
        if (Start) ph = P_RUN;
      end else if (ph == P_RUN) begin
        if (BlockDone) begin
          if (blk == blocks_per_mcu() - 1) begin
            blk = 0;
            pl  = 1'b1;
            if (mcu == int'(JpegMcuWidth) * int'(JpegMcuHeight) - 1) begin
              ph = P_DONE;
            end else begin
              mcu = mcu + 1;
              if (JpegRestart != 16'd0 && (mcu % int'(JpegRestart)) == 0) ph = P_ALIGN;
            end
          end else begin
            blk = blk + 1;
          end
        end
      end else if (ph == P_ALIGN) begin
        ph = P_WAIT;
      end else if (ph == P_WAIT) begin
        if (MarkerDone) ph = P_RUN;
      end
      mPhase <= ph;
      mBlk   <= blk;
      mMcu   <= mcu;
      mPulse <= pl;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [33:0] act, exp;
    logic [2:0]  eColor;
    logic [1:0]  eIndex;
    int nl;
    nl = luma_count();
    eColor = (mBlk < nl) ? 3'd0 : 3'(mBlk - nl + 1);
    eIndex = (mBlk < nl) ? 2'(mBlk) : 2'd0;
    act = {DecodeEnable, BlockColor, BlockIndex, McuX, McuY, McuDone, ResetDC, AlignReq, Finish};
    exp = {mPhase == P_RUN, eColor, eIndex,
           12'(mMcu % width_safe()), 12'(mMcu / width_safe()),
           mPulse, mPhase == P_ALIGN, mPhase == P_ALIGN, mPhase == P_DONE};
    check("model_cycle", 64'(act), 64'(exp));
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_block();
    BlockDone = 1'b1;
    @(negedge clk);
    BlockDone = 1'b0;
  endtask

  task automatic pulse_marker();
    MarkerDone = 1'b1;
    @(negedge clk);
    MarkerDone = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic setup(input int comp, input int sw, input int sh,
                       input int w, input int h, input int r);
    ProcessInit = 1'b1;
    @(negedge clk);
    ProcessInit  = 1'b0;
    JpegComp     = 3'(comp);
    SubSamplingW = 2'(sw);
    SubSamplingH = 2'(sh);
    JpegMcuWidth = 12'(w);
    JpegMcuHeight = 12'(h);
    JpegRestart  = 16'(r);
    pulse_start();
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] seqColor [6];
  logic [1:0] seqIndex [6];

  initial begin
    rst = 1'b0; ProcessInit = 1'b0; Start = 1'b0; BlockDone = 1'b0; MarkerDone = 1'b0;
    JpegComp = 3'd1; SubSamplingW = 2'd0; SubSamplingH = 2'd0;
    JpegMcuWidth = 12'd1; JpegMcuHeight = 12'd1; JpegRestart = 16'd0;
    tick(2);
    check("reset_outputs", 64'({DecodeEnable, BlockColor, BlockIndex, McuX, McuY,
                                McuDone, ResetDC, AlignReq, Finish}), 64'd0);
    rst = 1'b1;
    tick(1);

    // Grayscale 2x1, no restart.
    setup(1, 0, 0, 2, 1, 0);
    check("gray_run_enable", 64'(DecodeEnable), 64'd1);
    check("gray_mcux_start", 64'(McuX), 64'd0);
    pulse_start();                 // ignored while running
    pulse_block();
    check("gray_mcudone1", 64'(McuDone), 64'd1);
    check("gray_mcux_1", 64'(McuX), 64'd1);
    check("gray_finish_early", 64'(Finish), 64'd0);
    tick(1);
    check("gray_mcudone_pulse", 64'(McuDone), 64'd0);
    pulse_block();
    check("gray_mcudone2", 64'(McuDone), 64'd1);
    check("gray_finish", 64'(Finish), 64'd1);
    check("gray_hold_x", 64'(McuX), 64'd1);
    pulse_block();                 // ignored in DONE
    tick(2);
    check("gray_finish_level", 64'(Finish), 64'd1);
    check("gray_enable_off", 64'(DecodeEnable), 64'd0);

    // YCbCr 4:2:0 block order.
    seqColor = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2};
    seqIndex = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    setup(3, 1, 1, 2, 2, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("ycc420_color%0d", i), 64'(BlockColor), 64'(seqColor[i]));
      check($sformatf("ycc420_index%0d", i), 64'(BlockIndex), 64'(seqIndex[i]));
      check($sformatf("ycc420_nodone%0d", i), 64'(McuDone), 64'd0);
      pulse_block();
    end
    check("ycc420_mcudone", 64'(McuDone), 64'd1);
    check("ycc420_mcux", 64'(McuX), 64'd1);

    // Sub-sampling value 3 behaves as 1: 4:2:2 order Y0 Y1 Cb Cr.
    seqColor = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0};
    seqIndex = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    setup(3, 3, 0, 2, 2, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ycc422_color%0d", i), 64'(BlockColor), 64'(seqColor[i]));
      check($sformatf("ycc422_index%0d", i), 64'(BlockIndex), 64'(seqIndex[i]));
      pulse_block();
    end
    check("ycc422_mcudone", 64'(McuDone), 64'd1);

    // ProcessInit wins over a simultaneous BlockDone.
    setup(1, 0, 0, 4, 2, 0);
    pulse_block();
    BlockDone = 1'b1; ProcessInit = 1'b1;
    @(negedge clk);
    BlockDone = 1'b0; ProcessInit = 1'b0;
    check("init_prio_enable", 64'(DecodeEnable), 64'd0);
    check("init_prio_mcux", 64'(McuX), 64'd0);
    check("init_prio_mcudone", 64'(McuDone), 64'd0);

    // Restart every 3 MCUs in a 4x2 grayscale scan.
    setup(1, 0, 0, 4, 2, 3);
    pulse_block(); pulse_block(); pulse_block();
    check("rst3_align", 64'(AlignReq), 64'd1);
    check("rst3_resetdc", 64'(ResetDC), 64'd1);
    check("rst3_align_enable", 64'(DecodeEnable), 64'd0);
    check("rst3_align_x", 64'(McuX), 64'd3);
    tick(1);
    check("rst3_align_once", 64'(AlignReq), 64'd0);
    check("rst3_wait_enable", 64'(DecodeEnable), 64'd0);
    pulse_block();                 // ignored while waiting for the marker
    tick(3);
    check("rst3_wait_x", 64'(McuX), 64'd3);
    pulse_marker();
    check("rst3_resume", 64'(DecodeEnable), 64'd1);
    pulse_marker();                // ignored in RUN
    pulse_block();
    check("rst3_wrap_x", 64'(McuX), 64'd0);
    check("rst3_wrap_y", 64'(McuY), 64'd1);
    pulse_block(); pulse_block();
    check("rst3_align2", 64'(AlignReq), 64'd1);
    tick(2);
    pulse_marker();
    pulse_block(); pulse_block();
    check("rst3_finish", 64'(Finish), 64'd1);
    check("rst3_final_x", 64'(McuX), 64'd3);
    check("rst3_final_y", 64'(McuY), 64'd1);

    // Last MCU on a restart boundary goes straight to DONE.
    setup(1, 0, 0, 3, 1, 3);
    for (int i = 0; i < 3; i++) begin
      pulse_block();
      check($sformatf("lastrst_noalign%0d", i), 64'(AlignReq), 64'd0);
    end
    check("lastrst_finish", 64'(Finish), 64'd1);
    tick(2);
    check("lastrst_noalign_late", 64'(AlignReq), 64'd0);

    // Asynchronous reset in WAIT_MARK.
    setup(1, 0, 0, 4, 2, 3);
    pulse_block(); pulse_block(); pulse_block();
    tick(1);
    #2 rst = 1'b0;
    @(negedge clk);
    check("arst_outputs", 64'({DecodeEnable, BlockColor, BlockIndex, McuX, McuY,
                               McuDone, ResetDC, AlignReq, Finish}), 64'd0);
    rst = 1'b1;
    tick(1);
    pulse_marker();
    check("arst_marker_ignored", 64'(DecodeEnable), 64'd0);
    pulse_block();
    check("arst_block_ignored", 64'(McuDone), 64'd0);
    pulse_start();
    check("arst_start", 64'(DecodeEnable), 64'd1);
    check("arst_start_x", 64'(McuX), 64'd0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
